// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with a two-entry skid buffer.
// Upstream ready is registered; downstream sees the main slot.
module ex_mem_skid_stage #(
  parameter int LANES  = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  input  logic                    in_reg_write,
  input  logic                    in_vreg_write,
  input  logic                    in_mem_to_reg,
  input  logic                    in_branch,
  input  logic                    in_zero,
  input  logic                    in_mem_read_n,
  input  logic                    in_mem_write_n,
  input  logic [PC_W-1:0]         in_pc,
  input  logic [ADDR_W-1:0]       in_wr_addr,
  input  logic [DATA_W-1:0]       in_alu,
  input  logic [DATA_W-1:0]       in_store,
  input  logic [DATA_W-1:0]       in_rs2,
  input  logic [LANES-1:0]        in_vmask,
  input  logic [LANES*DATA_W-1:0] in_valu,
  output logic                    out_reg_write,
  output logic                    out_vreg_write,
  output logic                    out_mem_to_reg,
  output logic                    out_branch,
  output logic                    out_zero,
  output logic                    out_mem_read_n,
  output logic                    out_mem_write_n,
  output logic [PC_W-1:0]         out_pc,
  output logic [ADDR_W-1:0]       out_wr_addr,
  output logic [DATA_W-1:0]       out_alu,
  output logic [DATA_W-1:0]       out_store,
  output logic [DATA_W-1:0]       out_rs2,
  output logic [LANES-1:0]        out_vmask,
  output logic [LANES*DATA_W-1:0] out_valu,
  output logic [1:0]              occupancy,
  output logic [15:0]             stall_cycles
);

  typedef struct packed {
    logic                    reg_write;
    logic                    vreg_write;
    logic                    mem_to_reg;
    logic                    branch;
    logic                    zero;
    logic                    mem_read_n;
    logic                    mem_write_n;
    logic [PC_W-1:0]         pc;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       alu;
    logic [DATA_W-1:0]       store;
    logic [DATA_W-1:0]       rs2;
    logic [LANES-1:0]        vmask;
    logic [LANES*DATA_W-1:0] valu;
  } entry_t;

  function automatic entry_t rst_entry();
    entry_t e;
    e = '0;
    e.mem_read_n  = 1'b1;
    e.mem_write_n = 1'b1;
    return e;
  endfunction

  entry_t      main_q;
  entry_t      skid_q;
  entry_t      in_entry;
  logic        main_valid;
  logic        skid_valid;
  logic        in_ready_q;
  logic        in_xfer;
  logic        out_xfer;
  logic [15:0] stall_q;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = main_valid && out_ready;

  // Capture the incoming bundle, zeroing lanes not enabled by vmask.
  always_comb begin
    in_entry             = '0;
    in_entry.reg_write   = in_reg_write;
    in_entry.vreg_write  = in_vreg_write && (in_vmask != '0);
    in_entry.mem_to_reg  = in_mem_to_reg;
    in_entry.branch      = in_branch;
    in_entry.zero        = in_zero;
    in_entry.mem_read_n  = in_mem_read_n;
    in_entry.mem_write_n = in_mem_write_n;
    in_entry.pc          = in_pc;
    in_entry.wr_addr     = in_wr_addr;
    in_entry.alu         = in_alu;
    in_entry.store       = in_store;
    in_entry.rs2         = in_rs2;
    in_entry.vmask       = in_vmask;
    for (int i = 0; i < LANES; i++) begin
      in_entry.valu[i*DATA_W +: DATA_W] =
        in_vmask[i] ? in_valu[i*DATA_W +: DATA_W] : '0;
    end
  end

  // Slot occupancy and data movement; flush drops everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_q     <= rst_entry();
      skid_q     <= rst_entry();
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (!main_valid) begin
      if (in_xfer) begin
        main_q     <= in_entry;
        main_valid <= 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (in_xfer) begin
        main_q <= in_entry;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q     <= in_entry;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  // Count backpressured cycles, saturating; flush does not touch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = main_valid;
  assign occupancy       = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cycles    = stall_q;
  assign out_reg_write   = main_valid && main_q.reg_write;
  assign out_vreg_write  = main_valid && main_q.vreg_write;
  assign out_branch      = main_valid && main_q.branch;
  assign out_mem_read_n  = !main_valid || main_q.mem_read_n;
  assign out_mem_write_n = !main_valid || main_q.mem_write_n;
  assign out_vmask       = main_valid ? main_q.vmask : '0;
  assign out_mem_to_reg  = main_q.mem_to_reg;
  assign out_zero        = main_q.zero;
  assign out_pc          = main_q.pc;
  assign out_wr_addr     = main_q.wr_addr;
  assign out_alu         = main_q.alu;
  assign out_store       = main_q.store;
  assign out_rs2         = main_q.rs2;
  assign out_valu        = main_q.valu;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Bench for ex_mem_skid_stage: queue model plus directed checks.
// Outputs compared against the model on every falling edge.
module tb_ex_mem_skid_stage;

  localparam int L   = 8;
  localparam int DW  = 32;
  localparam int PW  = 16;
  localparam int AW  = 5;
  localparam int VW  = L * DW;
  localparam int PKW = 7 + PW + AW + 3 * DW + L + VW;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic          in_reg_write;
  logic          in_vreg_write;
  logic          in_mem_to_reg;
  logic          in_branch;
  logic          in_zero;
  logic          in_mem_read_n;
  logic          in_mem_write_n;
  logic [PW-1:0] in_pc;
  logic [AW-1:0] in_wr_addr;
  logic [DW-1:0] in_alu;
  logic [DW-1:0] in_store;
  logic [DW-1:0] in_rs2;
  logic [L-1:0]  in_vmask;
  logic [VW-1:0] in_valu;
  logic          out_reg_write;
  logic          out_vreg_write;
  logic          out_mem_to_reg;
  logic          out_branch;
  logic          out_zero;
  logic          out_mem_read_n;
  logic          out_mem_write_n;
  logic [PW-1:0] out_pc;
  logic [AW-1:0] out_wr_addr;
  logic [DW-1:0] out_alu;
  logic [DW-1:0] out_store;
  logic [DW-1:0] out_rs2;
  logic [L-1:0]  out_vmask;
  logic [VW-1:0] out_valu;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cycles;

  ex_mem_skid_stage #(
    .LANES(L), .DATA_W(DW), .PC_W(PW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush),
    .in_reg_write(in_reg_write), .in_vreg_write(in_vreg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_branch(in_branch),
    .in_zero(in_zero), .in_mem_read_n(in_mem_read_n),
    .in_mem_write_n(in_mem_write_n), .in_pc(in_pc),
    .in_wr_addr(in_wr_addr), .in_alu(in_alu),
    .in_store(in_store), .in_rs2(in_rs2),
    .in_vmask(in_vmask), .in_valu(in_valu),
    .out_reg_write(out_reg_write), .out_vreg_write(out_vreg_write),
    .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch),
    .out_zero(out_zero), .out_mem_read_n(out_mem_read_n),
    .out_mem_write_n(out_mem_write_n), .out_pc(out_pc),
    .out_wr_addr(out_wr_addr), .out_alu(out_alu),
    .out_store(out_store), .out_rs2(out_rs2),
    .out_vmask(out_vmask), .out_valu(out_valu),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic          rw;
    logic          vw;
    logic          m2r;
    logic          br;
    logic          z;
    logic          mrn;
    logic          mwn;
    logic [PW-1:0] pc;
    logic [AW-1:0] wa;
    logic [DW-1:0] alu;
    logic [DW-1:0] st;
    logic [DW-1:0] rs2;
    logic [L-1:0]  vm;
    logic [VW-1:0] valu;
  } ent_t;

  int            checks = 0;
  int            errors = 0;
  logic          chk_en = 1'b0;
  ent_t          q[$];
  ent_t          last;
  logic [15:0]   stall;
  logic [DW-1:0] seen[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [PKW-1:0] act,
                     input logic [PKW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic ent_t rst_ent();
    ent_t e;
    e = '0;
    e.mrn = 1'b1;
    e.mwn = 1'b1;
    return e;
  endfunction

  // What the stage must store for the current input bundle.
  function automatic ent_t mk();
    ent_t e;
    e.rw  = in_reg_write;
    e.vw  = in_vreg_write && (in_vmask != 0);
    e.m2r = in_mem_to_reg;
    e.br  = in_branch;
    e.z   = in_zero;
    e.mrn = in_mem_read_n;
    e.mwn = in_mem_write_n;
    e.pc  = in_pc;
    e.wa  = in_wr_addr;
    e.alu = in_alu;
    e.st  = in_store;
    e.rs2 = in_rs2;
    e.vm  = in_vmask;
    e.valu = '0;
    for (int i = 0; i < L; i++)
      if (in_vmask[i]) e.valu[i*DW +: DW] = in_valu[i*DW +: DW];
    return e;
  endfunction

  // Model: an ordered queue of at most two entries.
  always @(posedge clk) begin
    logic acc;
    if (!rst_n) begin
      q.delete();
      stall = 16'h0;
      last  = rst_ent();
    end else begin
      if (q.size() > 0 && !out_ready && stall != 16'hFFFF)
        stall = stall + 16'd1;
      if (flush) begin
        q.delete();
      end else begin
        acc = in_valid && (q.size() < 2);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(mk());
      end
      if (q.size() > 0) last = q[0];
    end
  end

  // Record values leaving the stage, in order.
  always @(posedge clk)
    if (rst_n && !flush && out_valid && out_ready)
      seen.push_back(out_alu);

  // Compare every output against the model each cycle.
  always @(negedge clk) begin
    ent_t e;
    logic v;
    if (chk_en) begin
      v = q.size() > 0;
      e = v ? q[0] : last;
      if (!v) begin
        e.rw = 1'b0; e.vw = 1'b0; e.br = 1'b0;
        e.vm = '0; e.mrn = 1'b1; e.mwn = 1'b1;
      end
      chk("out_valid", PKW'(out_valid), PKW'(v));
      chk("in_ready", PKW'(in_ready), PKW'(q.size() < 2));
      chk("occupancy", PKW'(occupancy), PKW'(q.size()));
      chk("stall_cycles", PKW'(stall_cycles), PKW'(stall));
      chk("payload",
          {out_reg_write, out_vreg_write, out_mem_to_reg, out_branch,
           out_zero, out_mem_read_n, out_mem_write_n, out_pc,
           out_wr_addr, out_alu, out_store, out_rs2, out_vmask,
           out_valu},
          PKW'(e));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [L-1:0] vm,
                       input logic vw);
    in_valid       = 1'b1;
    in_alu         = a;
    in_pc          = a[15:0] ^ 16'hA5C3;
    in_wr_addr     = a[4:0];
    in_store       = ~a;
    in_rs2         = a * 3;
    in_reg_write   = a[0];
    in_vreg_write  = vw;
    in_mem_to_reg  = a[1];
    in_branch      = a[2];
    in_zero        = a[3];
    in_mem_read_n  = a[4];
    in_mem_write_n = a[5];
    in_vmask       = vm;
    for (int i = 0; i < L; i++)
      in_valu[i*DW +: DW] = a + i * 32'h0101_0101;
  endtask

  task automatic idle();
    drive('0, '0, 1'b0);
    in_valid       = 1'b0;
    in_mem_read_n  = 1'b1;
    in_mem_write_n = 1'b1;
  endtask

  initial begin
    logic    acc;
    logic [VW-1:0] exp_valu;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle();
    step();
    chk_en = 1'b1;
    step();
    chk("rst out_valid", PKW'(out_valid), PKW'(0));
    chk("rst occupancy", PKW'(occupancy), PKW'(0));
    chk("rst in_ready", PKW'(in_ready), PKW'(1));
    chk("rst mem_read_n", PKW'(out_mem_read_n), PKW'(1));
    chk("rst mem_write_n", PKW'(out_mem_write_n), PKW'(1));
    chk("rst out_alu", PKW'(out_alu), PKW'(0));
    rst_n = 1'b1;
    step();

    // single entry, one-cycle latency
    out_ready = 1'b1;
    drive(32'h1234, 8'h0F, 1'b1);
    step();
    idle();
    chk("lat out_valid", PKW'(out_valid), PKW'(1));
    chk("lat out_alu", PKW'(out_alu), PKW'(32'h1234));
    chk("lat occupancy", PKW'(occupancy), PKW'(1));
    step();
    chk("lat drain occ", PKW'(occupancy), PKW'(0));

    // A, B, C under backpressure, then release
    seen.delete();
    out_ready = 1'b0;
    drive(32'd1, 8'hFE, 1'b1);
    step();
    drive(32'd2, 8'hFD, 1'b1);
    step();
    chk("skid in_ready", PKW'(in_ready), PKW'(0));
    chk("skid occ", PKW'(occupancy), PKW'(2));
    drive(32'd3, 8'hFC, 1'b1);
    step();
    step();
    chk("held out_alu", PKW'(out_alu), PKW'(1));
    chk("held occ", PKW'(occupancy), PKW'(2));
    out_ready = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) begin
      acc = in_ready;
      step();
    end
    chk("C accepted", PKW'(acc), PKW'(1));
    idle();
    repeat (4) step();
    chk("order count", PKW'(seen.size()), PKW'(3));
    if (seen.size() == 3) begin
      chk("order 0", PKW'(seen[0]), PKW'(1));
      chk("order 1", PKW'(seen[1]), PKW'(2));
      chk("order 2", PKW'(seen[2]), PKW'(3));
    end

    // streaming at full rate
    for (int i = 0; i < 20; i++) begin
      drive(32'd100 + i, 8'(i + 1), i[0]);
      step();
      chk("stream occ", PKW'(occupancy), PKW'(1));
      chk("stream in_ready", PKW'(in_ready), PKW'(1));
    end
    idle();
    repeat (2) step();

    // flush with both slots full and input pending
    seen.delete();
    out_ready = 1'b0;
    drive(32'd7, 8'h01, 1'b1);
    step();
    drive(32'd8, 8'h02, 1'b1);
    step();
    chk("pre-flush occ", PKW'(occupancy), PKW'(2));
    drive(32'd99, 8'h03, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("flush out_valid", PKW'(out_valid), PKW'(0));
    chk("flush occ", PKW'(occupancy), PKW'(0));
    chk("flush in_ready", PKW'(in_ready), PKW'(1));
    chk("flush mem_read_n", PKW'(out_mem_read_n), PKW'(1));
    out_ready = 1'b1;
    repeat (3) step();
    chk("flushed never out", PKW'(seen.size()), PKW'(0));

    // lane masking
    drive(32'h55, 8'b0000_0101, 1'b1);
    in_valu = '1;
    step();
    idle();
    exp_valu = {32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    chk("mask valu", PKW'(out_valu), PKW'(exp_valu));
    chk("mask vreg_write", PKW'(out_vreg_write), PKW'(1));
    chk("mask vmask", PKW'(out_vmask), PKW'(8'h05));
    drive(32'h66, 8'h00, 1'b1);
    in_valu = '1;
    step();
    idle();
    chk("zero mask vreg_write", PKW'(out_vreg_write), PKW'(0));
    chk("zero mask valu", PKW'(out_valu), PKW'(0));
    step();

    // mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      flush     = ($urandom % 16) == 0;
      out_ready = ($urandom % 3) != 0;
      if (($urandom % 4) != 0)
        drive($urandom, 8'($urandom), 1'($urandom));
      else
        in_valid = 1'b0;
      step();
    end
    flush = 1'b0;
    idle();

    // saturating stall counter, then reset mid-operation
    out_ready = 1'b0;
    drive(32'd11, 8'h11, 1'b1);
    step();
    drive(32'd12, 8'h12, 1'b1);
    step();
    idle();
    repeat (70000) step();
    chk("stall sat", PKW'(stall_cycles), PKW'(16'hFFFF));
    chk("stall occ", PKW'(occupancy), PKW'(2));
    rst_n = 1'b0;
    step();
    chk("rst2 stall", PKW'(stall_cycles), PKW'(0));
    chk("rst2 occ", PKW'(occupancy), PKW'(0));
    chk("rst2 out_valid", PKW'(out_valid), PKW'(0));
    chk("rst2 in_ready", PKW'(in_ready), PKW'(1));
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
